// File: rtl/hazard_scoreboard.sv
// Pending-write scoreboard: one saturating up/down counter per architectural register, x0 never tracked.
// stall/issue_accept are combinational from current counters; busy_vec/err_underflow follow events by one edge.
module hazard_scoreboard #(
   parameter  int NREG      = 32,
   parameter  int CNT_W     = 2,
   parameter  int WB_BYPASS = 1,
   localparam int IDX_W     = $clog2(NREG)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             issue_valid,
   input  logic             issue_rd_wr,
   input  logic [IDX_W-1:0] issue_rd_idx,
   input  logic             rs1_used,
   input  logic [IDX_W-1:0] rs1_idx,
   input  logic             rs2_used,
   input  logic [IDX_W-1:0] rs2_idx,
   input  logic             wb_valid,
   input  logic [IDX_W-1:0] wb_rd_idx,
   input  logic             kill_valid,
   input  logic [IDX_W-1:0] kill_rd_idx,
   output logic             stall,
   output logic             issue_accept,
   output logic [NREG-1:0]  busy_vec,
   output logic             err_underflow
);

   logic [NREG-1:0][CNT_W-1:0] cnt;
   logic [NREG-1:0][CNT_W-1:0] cnt_nxt;
   logic [NREG-1:0]            busy_nxt;
   logic [NREG-1:0]            uf_vec;
   logic [CNT_W:0]             up;
   logic [1:0]                 dn;

   logic [CNT_W-1:0] cnt_rs1, cnt_rs2, cnt_rd;
   logic             byp_rs1, byp_rs2;
   logic             hz_rs1, hz_rs2, hz_struct;

   assign cnt_rs1 = cnt[rs1_idx];
   assign cnt_rs2 = cnt[rs2_idx];
   assign cnt_rd  = cnt[issue_rd_idx];

   // A same-cycle WB only clears the hazard when it retires the last pending write.
   assign byp_rs1 = (WB_BYPASS != 0) && wb_valid && (wb_rd_idx == rs1_idx)
                    && (cnt_rs1 == CNT_W'(1));
   assign byp_rs2 = (WB_BYPASS != 0) && wb_valid && (wb_rd_idx == rs2_idx)
                    && (cnt_rs2 == CNT_W'(1));

   assign hz_rs1    = rs1_used && (rs1_idx != '0) && (cnt_rs1 != '0) && !byp_rs1;
   assign hz_rs2    = rs2_used && (rs2_idx != '0) && (cnt_rs2 != '0) && !byp_rs2;
   assign hz_struct = issue_rd_wr && (issue_rd_idx != '0) && (cnt_rd == '1);

   assign stall        = issue_valid && (hz_rs1 || hz_rs2 || hz_struct);
   assign issue_accept = issue_valid && !stall;

   // Index 0 is skipped entirely, so x0 never counts, never goes busy and never underflows.
   always_comb begin
      cnt_nxt  = '0;
      busy_nxt = '0;
      uf_vec   = '0;
      up       = '0;
      dn       = '0;
      for (int i = 1; i < NREG; i++) begin
         up = {1'b0, cnt[i]}
              + (CNT_W+1)'(issue_accept && issue_rd_wr && (issue_rd_idx == IDX_W'(i)));
         dn = 2'(wb_valid && (wb_rd_idx == IDX_W'(i)))
              + 2'(kill_valid && (kill_rd_idx == IDX_W'(i)));
         if (up < (CNT_W+1)'(dn)) begin
            uf_vec[i] = 1'b1;
         end else begin
            cnt_nxt[i] = CNT_W'(up - (CNT_W+1)'(dn));
         end
         busy_nxt[i] = (cnt_nxt[i] != '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt           <= '0;
         busy_vec      <= '0;
         err_underflow <= 1'b0;
      end else begin
         cnt           <= cnt_nxt;
         busy_vec      <= busy_nxt;
         err_underflow <= err_underflow || (|uf_vec);
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: stimulus pushes hand-computed expectations,
// a negedge monitor pops one record per cycle and compares stall/accept/busy/err.
module tb_hazard_scoreboard;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        issue_valid, issue_rd_wr, rs1_used, rs2_used, wb_valid, kill_valid;
   logic [4:0]  issue_rd_idx, rs1_idx, rs2_idx, wb_rd_idx, kill_rd_idx;
   logic        stall, issue_accept, err_underflow;
   logic [31:0] busy_vec;

   typedef struct {
      string       nm;
      logic        stall;
      logic        acc;
      logic [31:0] busy;
      logic        err;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0;
   int   n_err = 0;

   hazard_scoreboard #(.NREG(32), .CNT_W(2), .WB_BYPASS(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .issue_valid(issue_valid), .issue_rd_wr(issue_rd_wr), .issue_rd_idx(issue_rd_idx),
      .rs1_used(rs1_used), .rs1_idx(rs1_idx), .rs2_used(rs2_used), .rs2_idx(rs2_idx),
      .wb_valid(wb_valid), .wb_rd_idx(wb_rd_idx),
      .kill_valid(kill_valid), .kill_rd_idx(kill_rd_idx),
      .stall(stall), .issue_accept(issue_accept),
      .busy_vec(busy_vec), .err_underflow(err_underflow)
   );

   always #5 clk = ~clk;

   task automatic cmp(input string nm, input string fld, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s.%s got=%h want=%h", nm, fld, got, want);
      end
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         cmp(e.nm, "stall", {31'b0, stall}, {31'b0, e.stall});
         cmp(e.nm, "issue_accept", {31'b0, issue_accept}, {31'b0, e.acc});
         cmp(e.nm, "busy_vec", busy_vec, e.busy);
         cmp(e.nm, "err_underflow", {31'b0, err_underflow}, {31'b0, e.err});
      end
   end

   task automatic clr();
      issue_valid = 0; issue_rd_wr = 0; issue_rd_idx = 0;
      rs1_used = 0; rs1_idx = 0; rs2_used = 0; rs2_idx = 0;
      wb_valid = 0; wb_rd_idx = 0; kill_valid = 0; kill_rd_idx = 0;
   endtask

   // Expected busy/err are the registered values before this cycle's edge.
   task automatic chk(input string nm, input logic es, input logic ea,
                      input logic [31:0] eb, input logic ee);
      exp_t e;
      e.nm = nm; e.stall = es; e.acc = ea; e.busy = eb; e.err = ee;
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic iss(input int rd);
      issue_valid = 1; issue_rd_wr = 1; issue_rd_idx = 5'(rd);
   endtask

   initial begin
      rst_n = 0;
      clr();
      repeat (2) @(posedge clk);
      #1 rst_n = 1;

      // RAW on x5 with same-cycle WB bypass
      clr(); iss(5);                                      chk("raw_issue",   0, 1, 32'h0,  0);
      clr(); iss(6); rs1_used = 1; rs1_idx = 5;           chk("raw_stall1",  1, 0, 32'h20, 0);
      clr(); iss(6); rs1_used = 1; rs1_idx = 5;           chk("raw_stall2",  1, 0, 32'h20, 0);
      clr(); iss(6); rs1_used = 1; rs1_idx = 5;
             wb_valid = 1; wb_rd_idx = 5;                 chk("raw_bypass",  0, 1, 32'h20, 0);
      clr();                                              chk("raw_after",   0, 0, 32'h40, 0);
      clr(); wb_valid = 1; wb_rd_idx = 6;                 chk("raw_wb6",     0, 0, 32'h40, 0);
      clr();                                              chk("raw_clean",   0, 0, 32'h0,  0);

      // x0 is never tracked
      clr(); iss(0);                                      chk("x0_issue",    0, 1, 32'h0,  0);
      clr(); iss(0); rs1_used = 1; rs2_used = 1;          chk("x0_read",     0, 1, 32'h0,  0);
      clr(); wb_valid = 1; kill_valid = 1;                chk("x0_wbkill",   0, 0, 32'h0,  0);
      clr();                                              chk("x0_noerr",    0, 0, 32'h0,  0);

      // Saturation on x7 and rs2 bypass only at count 1
      clr(); iss(7);                                      chk("sat_1",       0, 1, 32'h0,  0);
      clr(); iss(7);                                      chk("sat_2",       0, 1, 32'h80, 0);
      clr(); iss(7);                                      chk("sat_3",       0, 1, 32'h80, 0);
      clr(); iss(7);                                      chk("sat_full",    1, 0, 32'h80, 0);
      clr(); iss(7); wb_valid = 1; wb_rd_idx = 7;         chk("sat_full_wb", 1, 0, 32'h80, 0);
      clr(); iss(7);                                      chk("sat_refill",  0, 1, 32'h80, 0);
      clr(); wb_valid = 1; wb_rd_idx = 7;                 chk("sat_wb_a",    0, 0, 32'h80, 0);
      clr(); issue_valid = 1; rs2_used = 1; rs2_idx = 7;
             wb_valid = 1; wb_rd_idx = 7;                 chk("rs2_nobyp",   1, 0, 32'h80, 0);
      clr(); issue_valid = 1; rs2_used = 1; rs2_idx = 7;
             wb_valid = 1; wb_rd_idx = 7;                 chk("rs2_byp",     0, 1, 32'h80, 0);
      clr();                                              chk("sat_clean",   0, 0, 32'h0,  0);

      // Simultaneous issue and WB on x9
      clr(); iss(9);                                      chk("sim_issue",   0, 1, 32'h0,   0);
      clr(); iss(9); wb_valid = 1; wb_rd_idx = 9;         chk("sim_both",    0, 1, 32'h200, 0);
      clr();                                              chk("sim_hold",    0, 0, 32'h200, 0);
      clr(); wb_valid = 1; wb_rd_idx = 9;                 chk("sim_wb",      0, 0, 32'h200, 0);
      clr();                                              chk("sim_clean",   0, 0, 32'h0,   0);

      // Kill of a pending write, then kill with nothing pending
      clr(); iss(3);                                      chk("kill_issue",  0, 1, 32'h0, 0);
      clr(); kill_valid = 1; kill_rd_idx = 3;             chk("kill_ok",     0, 0, 32'h8, 0);
      clr();                                              chk("kill_clean",  0, 0, 32'h0, 0);
      clr(); kill_valid = 1; kill_rd_idx = 4;             chk("uf_kill",     0, 0, 32'h0, 0);
      clr();                                              chk("uf_set",      0, 0, 32'h0, 1);
      clr();                                              chk("uf_sticky",   0, 0, 32'h0, 1);

      // Asynchronous reset with state outstanding
      clr(); iss(12);                                     chk("pre_rst",     0, 1, 32'h0,    1);
      clr();                                              chk("pre_rst_bv",  0, 0, 32'h1000, 1);
      clr(); issue_valid = 1; rs1_used = 1; rs1_idx = 12;
      rst_n = 0;                                          chk("in_rst",      0, 1, 32'h0,    0);
      rst_n = 1;
      clr();                                              chk("post_rst",    0, 0, 32'h0,    0);

      repeat (2) @(posedge clk);
      n_chk++;
      if (q.size() != 0) begin
         n_err++;
         $display("FAIL drain pending=%0d want=0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
